// File: rtl/regbank_pkg.sv
// Shared constants and word/address types for the 2-read/1-write register bank.
package regbank_pkg;

  localparam int REGBANK_DATA_W   = 16;
  localparam int REGBANK_NUM_REGS = 16;
  localparam int REGBANK_ADDR_W   = $clog2(REGBANK_NUM_REGS);

  typedef logic [REGBANK_ADDR_W-1:0] regbank_addr_t;
  typedef logic [REGBANK_DATA_W-1:0] regbank_data_t;

endpackage

// File: rtl/regbank_read_port.sv
// One registered read port: address mux, out-of-range zeroing, write-first bypass
// and the rd_data/rd_valid output registers.
module regbank_read_port
  import regbank_pkg::*;
#(
  parameter  int DATA_W   = REGBANK_DATA_W,
  parameter  int NUM_REGS = REGBANK_NUM_REGS,
  localparam int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] i_regs [NUM_REGS],
  input  logic              i_wr_accept,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_rd_valid
);

  localparam logic [ADDR_W:0] NUM_REGS_W = (ADDR_W+1)'(NUM_REGS);

  logic [DATA_W-1:0] w_mux;
  logic [DATA_W-1:0] w_next;
  logic              w_in_range;
  logic              w_bypass;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_rd_valid;

  // Select the addressed entry; a write landing on the same address wins.
  always_comb begin
    w_mux = {DATA_W{1'b0}};
    for (int i = 0; i < NUM_REGS; i++) begin
      w_mux = w_mux | ({DATA_W{i_rd_addr == ADDR_W'(i)}} & i_regs[i]);
    end
    w_in_range = ({1'b0, i_rd_addr} < NUM_REGS_W);
    // i_wr_accept is already cleared for dropped or hardwired-zero writes
    w_bypass   = i_wr_accept && (i_wr_addr == i_rd_addr);
    w_next     = w_bypass ? i_wr_data : (w_in_range ? w_mux : {DATA_W{1'b0}});
  end

  // Output registers: data holds when no read is requested.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_data  <= {DATA_W{1'b0}};
      r_rd_valid <= 1'b0;
    end else if (i_rd_en) begin
      r_rd_data  <= w_next;
      r_rd_valid <= 1'b1;
    end else begin
      r_rd_valid <= 1'b0;
    end
  end

  assign o_rd_data  = r_rd_data;
  assign o_rd_valid = r_rd_valid;

endmodule

// File: rtl/regbank_2r1w.sv
// Register bank with one binary-addressed write port and two registered read ports.
// Macro REGBANK_ZERO_REG_EN hardwires entry 0 to zero (no storage for it).
module regbank_2r1w
  import regbank_pkg::*;
#(
  parameter  int DATA_W   = REGBANK_DATA_W,
  parameter  int NUM_REGS = REGBANK_NUM_REGS,
  localparam int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en_a,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic [DATA_W-1:0] rd_data_a,
  output logic              rd_valid_a,
  input  logic              rd_en_b,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              rd_valid_b
);

`ifdef REGBANK_ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  localparam logic [ADDR_W:0] NUM_REGS_W = (ADDR_W+1)'(NUM_REGS);

  logic [DATA_W-1:0] w_regs [NUM_REGS];
  logic              w_wr_accept;

  // Out-of-range writes and writes to a hardwired zero entry are dropped here,
  // which also keeps them off the read-port bypass path.
  assign w_wr_accept = wr_en && ({1'b0, wr_addr} < NUM_REGS_W) &&
                       !(ZERO_REG && (wr_addr == {ADDR_W{1'b0}}));

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_entry
    if (ZERO_REG && (i == 0)) begin : g_zero
      assign w_regs[i] = {DATA_W{1'b0}};
    end else begin : g_store
      logic [DATA_W-1:0] r_reg;

      // Storage entry i: cleared by reset, loaded on an accepted matching write.
      always_ff @(posedge clk) begin
        if (reset) begin
          r_reg <= {DATA_W{1'b0}};
        end else if (w_wr_accept && (wr_addr == ADDR_W'(i))) begin
          r_reg <= wr_data;
        end
      end

      assign w_regs[i] = r_reg;
    end
  end

  regbank_read_port #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS)
  ) u_port_a (
    .clk         (clk),
    .reset       (reset),
    .i_regs      (w_regs),
    .i_wr_accept (w_wr_accept),
    .i_wr_addr   (wr_addr),
    .i_wr_data   (wr_data),
    .i_rd_en     (rd_en_a),
    .i_rd_addr   (rd_addr_a),
    .o_rd_data   (rd_data_a),
    .o_rd_valid  (rd_valid_a)
  );

  regbank_read_port #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS)
  ) u_port_b (
    .clk         (clk),
    .reset       (reset),
    .i_regs      (w_regs),
    .i_wr_accept (w_wr_accept),
    .i_wr_addr   (wr_addr),
    .i_wr_data   (wr_data),
    .i_rd_en     (rd_en_b),
    .i_rd_addr   (rd_addr_b),
    .o_rd_data   (rd_data_b),
    .o_rd_valid  (rd_valid_b)
  );

endmodule

// File: tb/tb_regbank_2r1w.sv
// Scoreboard bench for regbank_2r1w: a 16-entry bank (ports A/B) and a 12-entry bank.
module tb_regbank_2r1w;
  import regbank_pkg::*;

  typedef struct {
    logic          va;
    regbank_data_t da;
    logic          vb;
    regbank_data_t db;
  } exp_ab_t;

  typedef struct {
    logic          v;
    regbank_data_t d;
  } exp_c_t;

`ifdef REGBANK_ZERO_REG_EN
  localparam logic [15:0] Z0_EXP = 16'h0000;
`else
  localparam logic [15:0] Z0_EXP = 16'hFFFF;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_addr = 4'd0;
  logic [15:0] wr_data = 16'h0000;
  logic        rd_en_a = 1'b0;
  logic [3:0]  rd_addr_a = 4'd0;
  logic [15:0] rd_data_a;
  logic        rd_valid_a;
  logic        rd_en_b = 1'b0;
  logic [3:0]  rd_addr_b = 4'd0;
  logic [15:0] rd_data_b;
  logic        rd_valid_b;

  logic        c_reset = 1'b1;
  logic        c_wr_en = 1'b0;
  logic [3:0]  c_wr_addr = 4'd0;
  logic [15:0] c_wr_data = 16'h0000;
  logic        c_rd_en_a = 1'b0;
  logic [3:0]  c_rd_addr_a = 4'd0;
  logic [15:0] c_rd_data_a;
  logic        c_rd_valid_a;
  logic [15:0] c_rd_data_b;
  logic        c_rd_valid_b;

  int checks = 0;
  int errors = 0;

  exp_ab_t q_ab[$];
  exp_c_t  q_c[$];
  logic [15:0] hold_a = 16'h0000;
  logic [15:0] hold_b = 16'h0000;
  logic [15:0] hold_c = 16'h0000;

  always #5 clk = ~clk;

  regbank_2r1w dut (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a), .rd_valid_a(rd_valid_a),
    .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b), .rd_valid_b(rd_valid_b)
  );

  regbank_2r1w #(.NUM_REGS(12)) dut12 (
    .clk(clk), .reset(c_reset),
    .wr_en(c_wr_en), .wr_addr(c_wr_addr), .wr_data(c_wr_data),
    .rd_en_a(c_rd_en_a), .rd_addr_a(c_rd_addr_a), .rd_data_a(c_rd_data_a), .rd_valid_a(c_rd_valid_a),
    .rd_en_b(1'b0), .rd_addr_b(4'd0), .rd_data_b(c_rd_data_b), .rd_valid_b(c_rd_valid_b)
  );

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // One cycle on the 16-entry bank; xa/xb are the data expected when that port reads.
  task automatic step(input logic rst, input logic we, input logic [3:0] wa, input logic [15:0] wd,
                      input logic ea, input logic [3:0] aa, input logic eb, input logic [3:0] ab,
                      input logic [15:0] xa, input logic [15:0] xb);
    exp_ab_t e;
    @(negedge clk);
    reset = rst; wr_en = we; wr_addr = wa; wr_data = wd;
    rd_en_a = ea; rd_addr_a = aa; rd_en_b = eb; rd_addr_b = ab;
    @(posedge clk);
    e.va = ea && !rst;
    e.da = rst ? 16'h0000 : (ea ? xa : hold_a);
    e.vb = eb && !rst;
    e.db = rst ? 16'h0000 : (eb ? xb : hold_b);
    hold_a = e.da;
    hold_b = e.db;
    q_ab.push_back(e);
  endtask

  task automatic step12(input logic rst, input logic we, input logic [3:0] wa, input logic [15:0] wd,
                        input logic ea, input logic [3:0] aa, input logic [15:0] xa);
    exp_c_t e;
    @(negedge clk);
    c_reset = rst; c_wr_en = we; c_wr_addr = wa; c_wr_data = wd;
    c_rd_en_a = ea; c_rd_addr_a = aa;
    @(posedge clk);
    e.v = ea && !rst;
    e.d = rst ? 16'h0000 : (ea ? xa : hold_c);
    hold_c = e.d;
    q_c.push_back(e);
  endtask

  // Monitor: compare whatever the DUTs present against the oldest expectation.
  always @(negedge clk) begin
    if (q_ab.size() > 0) begin
      exp_ab_t e;
      e = q_ab.pop_front();
      chk("valid_a", {15'd0, rd_valid_a}, {15'd0, e.va});
      chk("data_a", rd_data_a, e.da);
      chk("valid_b", {15'd0, rd_valid_b}, {15'd0, e.vb});
      chk("data_b", rd_data_b, e.db);
    end
    if (q_c.size() > 0) begin
      exp_c_t e;
      e = q_c.pop_front();
      chk("valid_c", {15'd0, c_rd_valid_a}, {15'd0, e.v});
      chk("data_c", c_rd_data_a, e.d);
    end
  end

  initial begin
    // reset state
    step(1'b1, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 1'b0, 4'd0, 16'h0000, 16'h0000);
    step(1'b1, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 1'b0, 4'd0, 16'h0000, 16'h0000);
    // back-to-back reads of every address after reset
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b0, 4'd0, 16'h0000, 1'b1, 4'(i), 1'b1, 4'(15 - i), 16'h0000, 16'h0000);
    end
    step(1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 1'b0, 4'd0, 16'h0000, 16'h0000);
    // write r3 then read it; idle cycle checks data hold with valid low
    step(1'b0, 1'b1, 4'd3, 16'hA5A5, 1'b0, 4'd0, 1'b0, 4'd0, 16'h0000, 16'h0000);
    step(1'b0, 1'b0, 4'd0, 16'h0000, 1'b1, 4'd3, 1'b0, 4'd0, 16'hA5A5, 16'h0000);
    step(1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 1'b0, 4'd0, 16'h0000, 16'h0000);
    // write-first bypass on both ports
    step(1'b0, 1'b1, 4'd7, 16'h0FFF, 1'b0, 4'd0, 1'b0, 4'd0, 16'h0000, 16'h0000);
    step(1'b0, 1'b1, 4'd7, 16'h1234, 1'b1, 4'd7, 1'b1, 4'd7, 16'h1234, 16'h1234);
    step(1'b0, 1'b0, 4'd0, 16'h0000, 1'b1, 4'd7, 1'b1, 4'd3, 16'h1234, 16'hA5A5);
    // reset dominates an in-flight read and a same-cycle write
    step(1'b0, 1'b1, 4'd5, 16'hBEEF, 1'b0, 4'd0, 1'b0, 4'd0, 16'h0000, 16'h0000);
    step(1'b1, 1'b1, 4'd9, 16'h1111, 1'b1, 4'd5, 1'b1, 4'd7, 16'h0000, 16'h0000);
    step(1'b0, 1'b0, 4'd0, 16'h0000, 1'b1, 4'd5, 1'b1, 4'd9, 16'h0000, 16'h0000);
    // bypass on A while B reads a cleared entry
    step(1'b0, 1'b1, 4'd2, 16'h0002, 1'b1, 4'd2, 1'b1, 4'd3, 16'h0002, 16'h0000);
    // address 0: bypass edge and the following edge
    step(1'b0, 1'b1, 4'd0, 16'hFFFF, 1'b1, 4'd0, 1'b1, 4'd0, Z0_EXP, Z0_EXP);
    step(1'b0, 1'b0, 4'd0, 16'h0000, 1'b1, 4'd0, 1'b1, 4'd0, Z0_EXP, Z0_EXP);
    // top address
    step(1'b0, 1'b1, 4'd15, 16'hCAFE, 1'b0, 4'd0, 1'b0, 4'd0, 16'h0000, 16'h0000);
    step(1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 1'b1, 4'd15, 16'h0000, 16'hCAFE);
    step(1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 1'b0, 4'd0, 16'h0000, 16'h0000);

    // 12-entry bank: out-of-range writes dropped, out-of-range reads return 0
    step12(1'b1, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000);
    for (int i = 0; i < 12; i++) begin
      step12(1'b0, 1'b1, 4'(i), 16'h1000 + 16'(i), 1'b0, 4'd0, 16'h0000);
    end
    step12(1'b0, 1'b1, 4'd13, 16'h5555, 1'b0, 4'd0, 16'h0000);
    step12(1'b0, 1'b1, 4'd12, 16'h7777, 1'b1, 4'd12, 16'h0000);
    step12(1'b0, 1'b0, 4'd0, 16'h0000, 1'b1, 4'd13, 16'h0000);
`ifdef REGBANK_ZERO_REG_EN
    step12(1'b0, 1'b0, 4'd0, 16'h0000, 1'b1, 4'd0, 16'h0000);
    for (int i = 1; i < 12; i++) begin
`else
    for (int i = 0; i < 12; i++) begin
`endif
      step12(1'b0, 1'b0, 4'd0, 16'h0000, 1'b1, 4'(i), 16'h1000 + 16'(i));
    end
    step12(1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000);

    repeat (2) @(negedge clk);
    #1;
    chk("drain_ab", 16'(q_ab.size()), 16'h0000);
    chk("drain_c", 16'(q_c.size()), 16'h0000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
